// File: rtl/gate_steer_pkg.sv
// Shared types and constants for the gate_steer divider-steering block.
// Optional feature macro: GATE_STEER_DONE_COUNT_EN (completed-command counter).
package gate_steer_pkg;

    // Externally visible command state; RUN is owned by the top level,
    // the other three by the byte deframer.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_HI    = 2'd1,
        ST_RUN   = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    // Bit of byte1 that carries the steering direction (1 = fdec, 0 = finc).
    localparam int SIGN_BIT = 7;

    // Bytes per command frame.
    localparam int FRAME_LEN = 2;

    // Magnitude bits carried by one frame: all frame bits minus the sign bit.
    localparam int FRAME_MAG_BITS = 8 * FRAME_LEN - 1;

    // Default width of the period down-counter.
    localparam int DEFAULT_MAG_WIDTH = 15;

endpackage

// File: rtl/gate_steer_rx.sv
// Command byte deframer: IDLE/HI/DRAIN state machine, framing error detection
// and single-cycle command pulses toward the steering logic.
// Optional feature macro: GATE_STEER_DONE_COUNT_EN (not used in this file).
module gate_steer_rx
    import gate_steer_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst,
    input  logic [7:0]                tdata,
    input  logic                      tlast,
    input  logic                      xfer,
    output logic                      cmd_go,
    output logic                      cmd_zero,
    output logic [FRAME_MAG_BITS-1:0] cmd_mag,
    output logic                      cmd_sign,
    output logic                      err_set,
    output state_t                    state
);

    state_t     state_q;
    state_t     state_d;
    logic [7:0] lo_q;

    // Magnitude as seen while the second byte is on the bus.
    assign cmd_mag  = {tdata[SIGN_BIT-1:0], lo_q};
    assign cmd_sign = tdata[SIGN_BIT];
    assign state    = state_q;

    // State register and low-byte capture; reset drops any partial frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            lo_q    <= 8'h00;
        end else begin
            state_q <= state_d;
            if (state_q == ST_IDLE && xfer && !tlast) begin
                lo_q <= tdata;
            end
        end
    end

    // Next-state and command/error pulses; every pulse qualifies on xfer.
    always_comb begin
        state_d  = state_q;
        cmd_go   = 1'b0;
        cmd_zero = 1'b0;
        err_set  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (xfer) begin
                    if (tlast) begin
                        err_set = 1'b1;
                    end else begin
                        state_d = ST_HI;
                    end
                end
            end
            ST_HI: begin
                if (xfer) begin
                    if (tlast) begin
                        if (cmd_mag != '0) begin
                            cmd_go = 1'b1;
                        end else begin
                            cmd_zero = 1'b1;
                        end
                        state_d = ST_IDLE;
                    end else begin
                        err_set = 1'b1;
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (xfer && tlast) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule

// File: rtl/gate_steer.sv
// Gate-divider steering: receives 2-byte commands and holds o_fdec or o_finc
// high for exactly mag divider reloads (i_period_tick pulses).
// Optional feature macro: GATE_STEER_DONE_COUNT_EN adds o_done_count.
//
// Handshake: a byte transfers on a rising edge where i_s_axis_tvalid and
// o_s_axis_tready are both high; tready is a function of registered state
// only (low during reset and while a command runs), never of tvalid.
module gate_steer
    import gate_steer_pkg::*;
#(
    parameter int MAG_WIDTH = DEFAULT_MAG_WIDTH
) (
    input  logic        i_clk_gate,
    input  logic        rst_gate,
    input  logic [7:0]  i_s_axis_tdata,
    input  logic        i_s_axis_tvalid,
    output logic        o_s_axis_tready,
    input  logic        i_s_axis_tlast,
    input  logic        i_period_tick,
    output logic        o_fdec,
    output logic        o_finc,
    output logic        o_busy,
    output logic        o_err,
    input  logic        i_err_clr,
    output state_t      dbg_state
`ifdef GATE_STEER_DONE_COUNT_EN
    ,
    output logic [15:0] o_done_count
`endif
);

    logic                      ready_en_q;
    logic                      xfer;
    logic                      cmd_go;
    logic                      cmd_zero;
    logic [FRAME_MAG_BITS-1:0] cmd_mag;
    logic                      cmd_sign;
    logic                      err_set;
    state_t                    rx_state;
    logic [MAG_WIDTH-1:0]      cnt_q;
    logic                      run_done;

    assign o_s_axis_tready = ready_en_q && !o_busy;
    assign xfer            = i_s_axis_tvalid && o_s_axis_tready;

    // Final reload of the running command: strobe drops on the next edge.
    assign run_done = o_busy && i_period_tick && (cnt_q == MAG_WIDTH'(1));

    gate_steer_rx u_rx (
        .clk      (i_clk_gate),
        .rst      (rst_gate),
        .tdata    (i_s_axis_tdata),
        .tlast    (i_s_axis_tlast),
        .xfer     (xfer),
        .cmd_go   (cmd_go),
        .cmd_zero (cmd_zero),
        .cmd_mag  (cmd_mag),
        .cmd_sign (cmd_sign),
        .err_set  (err_set),
        .state    (rx_state)
    );

    // Keeps tready low through reset and raises it the first cycle after release.
    always_ff @(posedge i_clk_gate or posedge rst_gate) begin
        if (rst_gate) begin
            ready_en_q <= 1'b0;
        end else begin
            ready_en_q <= 1'b1;
        end
    end

    // RUN: load on command, count reloads, clear strobe after the last one.
    // A tick coinciding with the load is ignored because the load wins.
    always_ff @(posedge i_clk_gate or posedge rst_gate) begin
        if (rst_gate) begin
            cnt_q  <= '0;
            o_busy <= 1'b0;
            o_fdec <= 1'b0;
            o_finc <= 1'b0;
        end else if (cmd_go) begin
            cnt_q  <= MAG_WIDTH'(cmd_mag);
            o_busy <= 1'b1;
            o_fdec <= cmd_sign;
            o_finc <= !cmd_sign;
        end else if (run_done) begin
            cnt_q  <= '0;
            o_busy <= 1'b0;
            o_fdec <= 1'b0;
            o_finc <= 1'b0;
        end else if (o_busy && i_period_tick) begin
            cnt_q <= cnt_q - MAG_WIDTH'(1);
        end
    end

    // Sticky framing error; a same-cycle set beats the clear.
    always_ff @(posedge i_clk_gate or posedge rst_gate) begin
        if (rst_gate) begin
            o_err <= 1'b0;
        end else if (err_set) begin
            o_err <= 1'b1;
        end else if (i_err_clr) begin
            o_err <= 1'b0;
        end
    end

    // Observable command state: RUN while busy, otherwise the deframer state.
    always_comb begin
        dbg_state = rx_state;
        if (o_busy) begin
            dbg_state = ST_RUN;
        end
    end

`ifdef GATE_STEER_DONE_COUNT_EN
    // Completed commands, including zero-magnitude no-ops; wraps naturally.
    always_ff @(posedge i_clk_gate or posedge rst_gate) begin
        if (rst_gate) begin
            o_done_count <= 16'h0000;
        end else if (run_done || cmd_zero) begin
            o_done_count <= o_done_count + 16'h0001;
        end
    end
`endif

endmodule
